// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter
//   Arbitrates N_MASTER cache-bus masters (index 0 = ibus, index 1 = dbus) onto
//   one downstream cache-bus request. A grant is held for the whole transaction
//   (every burst beat). After the transaction the block re-arbitrates. Responses
//   are routed only to the granted master. There is no data buffering: while a
//   transaction is active, the request path is a pure grant mux.
//
//   Optional feature: define CBUS_ARB_ROUND_ROBIN_EN to select round-robin
//   arbitration. When it is not defined, arbitration uses fixed priority and
//   the highest index wins.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   m_valid/m_is_write    per-master request valid / write flag
//   m_size/m_addr/m_len   per-master size, start address, burst length
//   m_strobe/m_wdata      per-master current-beat strobe and write data
//   m_ready/m_last        per-master beat handshake / final beat
//   m_rdata               per-master read data
//   s_*                   downstream request (valid, is_write, size, addr,
//                         strobe, wdata, len)
//   s_ready/s_last        downstream beat handshake / final beat
//   s_rdata               downstream read data
//   grant_idx             index of the current or most recent owner (debug)
// -----------------------------------------------------------------------------
module cbus_arbiter #(
  parameter int N_MASTER = 2,
  parameter int LEN_W    = 4,
  localparam int IDX_W   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_MASTER-1:0]       m_valid,
  input  logic [N_MASTER-1:0]       m_is_write,
  input  logic [3*N_MASTER-1:0]     m_size,
  input  logic [32*N_MASTER-1:0]    m_addr,
  input  logic [4*N_MASTER-1:0]     m_strobe,
  input  logic [32*N_MASTER-1:0]    m_wdata,
  input  logic [LEN_W*N_MASTER-1:0] m_len,
  output logic [N_MASTER-1:0]       m_ready,
  output logic [N_MASTER-1:0]       m_last,
  output logic [32*N_MASTER-1:0]    m_rdata,
  output logic                      s_valid,
  output logic                      s_is_write,
  output logic [2:0]                s_size,
  output logic [31:0]               s_addr,
  output logic [3:0]                s_strobe,
  output logic [31:0]               s_wdata,
  output logic [LEN_W-1:0]          s_len,
  input  logic                      s_ready,
  input  logic                      s_last,
  input  logic [31:0]               s_rdata,
  output logic [IDX_W-1:0]          grant_idx
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] winner;
  logic             busy;
  logic             owner_valid;
  logic             release_now;
  int               g_int;

  assign busy        = (state_q == BUSY);
  assign g_int       = int'(grant_q);
  assign owner_valid = m_valid[grant_q];
  // The transaction ends on the final handshake. It also ends when the owner
  // withdraws its request, because that aborts the transaction.
  assign release_now = busy && (!owner_valid || (s_ready && s_last));

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  int               rr_cand;

  // Search for the first requester strictly after the previous owner, with
  // wrap-around. The last step of the search (k == N_MASTER) re-checks the
  // previous owner, so a lone requester can always win again.
  always_comb begin
    winner  = '0;
    rr_cand = 0;
    for (int k = N_MASTER; k >= 1; k--) begin
      rr_cand = (int'(last_grant_q) + k) % N_MASTER;
      if (m_valid[rr_cand]) winner = IDX_W'(rr_cand);
    end
  end

  always_comb begin
    last_grant_d = release_now ? grant_q : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= '0;
    else       last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: the highest requesting index wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (m_valid[i]) winner = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|m_valid) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        if (release_now) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  assign grant_idx = grant_q;

  // The request path is combinational from the owner, so wdata and strobe
  // follow each beat. s_valid drops in the same cycle that the owner withdraws.
  assign s_valid    = busy && owner_valid;
  assign s_is_write = busy ? m_is_write[grant_q] : 1'b0;
  assign s_size     = busy ? m_size[g_int*3 +: 3] : 3'd0;
  assign s_addr     = busy ? m_addr[g_int*32 +: 32] : 32'd0;
  assign s_strobe   = busy ? m_strobe[g_int*4 +: 4] : 4'd0;
  assign s_wdata    = busy ? m_wdata[g_int*32 +: 32] : 32'd0;
  assign s_len      = busy ? m_len[g_int*LEN_W +: LEN_W] : '0;

  // Only the owner sees the response. All other masters see zeros.
  for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_resp
    logic sel;
    assign sel                   = busy && (grant_q == IDX_W'(gi));
    assign m_ready[gi]           = sel & s_ready;
    assign m_last[gi]            = sel & s_last;
    assign m_rdata[gi*32 +: 32]  = sel ? s_rdata : 32'd0;
  end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Arbitrates N cache-bus masters (instruction and data side of VTop) onto a single cache-bus request that feeds the CBus-to-AXI converter.
- Sits between the core's ibus/dbus ports and the `oreq`/`oresp` pair in the AXI build of mycpu_top.
- Holds a grant for the whole transaction, including every burst beat, then re-arbitrates.
- Routes the response only to the granted master.

Parameters:
- N_MASTER, 2: number of upstream masters. Index 0 is ibus, index 1 is dbus.
- LEN_W, 4: width of the burst length field (beats = len+1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_valid  in  N_MASTER  per-master request valid; held high until that master's last beat completes
- m_is_write  in  N_MASTER  per-master write flag
- m_size  in  3*N_MASTER  per-master transfer size
- m_addr  in  32*N_MASTER  per-master start address
- m_strobe  in  4*N_MASTER  per-master byte strobe (current beat)
- m_wdata  in  32*N_MASTER  per-master write data (current beat)
- m_len  in  LEN_W*N_MASTER  per-master burst length
- m_ready  out  N_MASTER  per-master beat handshake
- m_last  out  N_MASTER  per-master final beat
- m_rdata  out  32*N_MASTER  per-master read data
- s_valid, s_is_write, s_size, s_addr, s_strobe, s_wdata, s_len  out  1/1/3/32/4/32/LEN_W  downstream request
- s_ready, s_last  in  1/1  downstream beat handshake / final beat
- s_rdata  in  32  downstream read data
- grant_idx  out  $clog2(N_MASTER)  index of the owner, for debug

Behaviour:
- FSM has two states: IDLE and BUSY.
- Reset puts the FSM in IDLE and sets grant_idx=0. All s_* request outputs and all m_ready/m_last/m_rdata are 0.
- Reset asserted mid-transaction aborts it immediately. Outputs return to the reset values on the next edge. There is no drain.
- IDLE:
  - s_valid=0 and every m_ready=0.
  - If any m_valid is high, choose a winner per the priority rule, register its index into grant_idx, and move to BUSY on the next edge.
- BUSY:
  - The s_* request outputs equal the granted master's inputs, combinationally, every cycle. Per-beat wdata/strobe therefore pass through.
  - m_ready[g]=s_ready, m_last[g]=s_last, m_rdata[g]=s_rdata. Every other master sees ready=0, last=0, rdata=0.
- Release:
  - s_ready&&s_last in BUSY means next state is IDLE.
  - If m_valid[g] drops while in BUSY, the block returns to IDLE next edge and forces s_valid=0 that cycle.
- Latency:
  - Master m_valid rising in IDLE gives s_valid one cycle later.
  - After the last beat there is one IDLE bubble cycle before the next grant. Back-to-back transactions therefore have a minimum of 1 dead cycle.
- Priority, default: fixed. The highest index wins (dbus over ibus).
- Requests arriving while BUSY wait; they are never dropped and never reordered within a master.
- Simultaneous last beat and new request: the new request is evaluated in the following IDLE cycle.
- Purely a router: no buffering of data. The s_* combinational paths only go through the grant mux.

Optional Feature:
- Macro: CBUS_ARB_ROUND_ROBIN_EN.
- Defined: a registered last_grant (reset 0) is updated on each release. In IDLE the winner is the first requesting index strictly after last_grant, with wrap-around modulo N_MASTER. This prevents ibus starvation.
- Undefined: fixed priority as above. last_grant logic is absent.

Test Plan:
- Single read: reset, then m_valid[0]=1, addr=0xBFC00000, len=0. Expect s_valid=1 on cycle+1 with s_addr=0xBFC00000. Drive s_ready=s_last=1 with s_rdata=0x3C1D8000. Expect m_ready[0]=m_last[0]=1, m_rdata[0]=0x3C1D8000, m_ready[1]=0, and IDLE next cycle.
- Burst write: m_valid[1], is_write=1, len=3, wdata beats 0x11,0x22,0x33,0x44 with s_ready every other cycle. Expect s_wdata to track each beat, exactly 4 m_ready[1] pulses, m_last[1] only on the 4th, and grant_idx=1 throughout.
- Contention, fixed priority: both m_valid rise the same cycle. Expect grant_idx=1 first. After its last beat: 1 idle cycle, then grant_idx=0. m_ready[0] stays 0 during master 1's transfer.
- Contention, round robin (macro defined): both masters continuously requesting with len=0. Expect grants 1,0,1,0 over 4 transactions.
- Abort/reset: reset asserted during beat 2 of a len=3 read. Expect s_valid=0, all m_ready=0, grant_idx=0 next cycle. In a separate run, m_valid[g] is dropped mid-burst; expect s_valid=0 that cycle and IDLE next.
